// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed common-anode 7-segment scan driver
// Snapshots number once per frame and scans it out one digit per SCAN_DIV cycles.
module seg7_scan_driver #(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter logic        BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] number,
    input  logic [3:0]  enable,
    input  logic        hold,
    output logic [6:0]  a_to_g,
    output logic [3:0]  num_en
);

    logic [15:0] div_cnt_q, div_cnt_d;
    logic [1:0]  dig_q, dig_d;
    logic [15:0] shadow_q, shadow_d;
    logic [6:0]  a_to_g_q, a_to_g_d;
    logic [3:0]  num_en_q, num_en_d;
    logic        tick;
    logic [3:0]  nib;
    logic        lead_zero;
    logic        blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        tick     = (div_cnt_q == SCAN_DIV - 16'd1);
        div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
        dig_d    = tick ? dig_q + 2'd1 : dig_q;
        // Sampling only on the 3->0 wrap keeps every frame internally consistent.
        shadow_d = (tick && dig_q == 2'd3 && !hold) ? number : shadow_q;

        nib       = 4'h0;
        lead_zero = 1'b0;
        case (dig_q)
            2'd0: begin nib = shadow_q[3:0];   lead_zero = 1'b0;                   end
            2'd1: begin nib = shadow_q[7:4];   lead_zero = (shadow_q[15:4] == 12'h0); end
            2'd2: begin nib = shadow_q[11:8];  lead_zero = (shadow_q[15:8] == 8'h0);  end
            default: begin nib = shadow_q[15:12]; lead_zero = (shadow_q[15:12] == 4'h0); end
        endcase

        blank    = ~enable[dig_q] | (BLANK_LZ & (dig_q != 2'd0) & lead_zero);
        a_to_g_d = blank ? 7'h7F : hex7(nib);
        num_en_d = blank ? 4'b1111 : ~(4'b0001 << dig_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= 16'd0;
            dig_q     <= 2'd0;
            shadow_q  <= 16'h0000;
            a_to_g_q  <= 7'b1111111;
            num_en_q  <= 4'b1111;
        end else begin
            div_cnt_q <= div_cnt_d;
            dig_q     <= dig_d;
            shadow_q  <= shadow_d;
            a_to_g_q  <= a_to_g_d;
            num_en_q  <= num_en_d;
        end
    end

    assign a_to_g = a_to_g_q;
    assign num_en = num_en_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
// Three instances: SCAN_DIV=4, SCAN_DIV=4 with leading-zero blanking, SCAN_DIV=1.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] number = 16'h1234;
    logic [3:0]  enable = 4'hF;
    logic        hold = 1'b0;
    logic [6:0]  seg_w [3];
    logic [3:0]  en_w  [3];

    int tests = 0;
    int fails = 0;
    int ecount = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(16'd4), .BLANK_LZ(1'b0)) u_dut (
        .clk(clk), .reset(reset), .number(number), .enable(enable), .hold(hold),
        .a_to_g(seg_w[0]), .num_en(en_w[0]));
    seg7_scan_driver #(.SCAN_DIV(16'd4), .BLANK_LZ(1'b1)) u_lz (
        .clk(clk), .reset(reset), .number(number), .enable(enable), .hold(hold),
        .a_to_g(seg_w[1]), .num_en(en_w[1]));
    seg7_scan_driver #(.SCAN_DIV(16'd1), .BLANK_LZ(1'b0)) u_fast (
        .clk(clk), .reset(reset), .number(number), .enable(enable), .hold(hold),
        .a_to_g(seg_w[2]), .num_en(en_w[2]));

    function automatic int div_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic logic [6:0] seg_code(input int v);
        logic [6:0] tbl [16];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return tbl[v];
    endfunction

    // Model: cycle count since reset, digit = (cycles / div) mod 4, snapshot on frame boundary.
    int         cyc [3];
    int         shd [3];
    logic [6:0] es  [3];
    logic [3:0] ee  [3];
    bit         model_ok = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ecount = 0;
            model_ok = 1'b1;
            for (int i = 0; i < 3; i++) begin
                cyc[i] = 0; shd[i] = 0; es[i] = 7'h7F; ee[i] = 4'hF;
            end
        end else begin
            ecount = ecount + 1;
            for (int i = 0; i < 3; i++) begin
                int d;
                int upper;
                bit blank;
                d = (cyc[i] / div_of(i)) % 4;
                upper = shd[i] >> (4 * d);
                blank = (enable[d] == 1'b0) || (i == 1 && d != 0 && upper == 0);
                es[i] = blank ? 7'h7F : seg_code(upper % 16);
                ee[i] = blank ? 4'hF : 4'(15 - (1 << d));
                if (((cyc[i] + 1) % (4 * div_of(i))) == 0 && !hold)
                    shd[i] = int'(number);
                cyc[i] = cyc[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [6:0] gs, input logic [3:0] ge,
                       input logic [6:0] xs, input logic [3:0] xe);
        tests++;
        if (gs !== xs || ge !== xe) begin
            fails++;
            $display("FAIL %s: got a_to_g=%b num_en=%b, want a_to_g=%b num_en=%b", nm, gs, ge, xs, xe);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("model u%0d edge%0d", i, ecount), seg_w[i], en_w[i], es[i], ee[i]);
        end
    end

    task automatic goto(input int k);
        int guard = 0;
        while (ecount < k && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (ecount != k) begin
            fails++;
            $display("FAIL goto: edge count %0d, wanted %0d", ecount, k);
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("in_reset u%0d", i), seg_w[i], en_w[i], 7'h7F, 4'hF);
        reset = 1'b0;

        goto(1);  chk("first d0", seg_w[0], en_w[0], 7'b0000001, 4'b1110);
        goto(5);  chk("first d1", seg_w[0], en_w[0], 7'b0000001, 4'b1101);
        goto(17); chk("1234 d0", seg_w[0], en_w[0], 7'b1001100, 4'b1110);
        goto(21); chk("1234 d1", seg_w[0], en_w[0], 7'b0000110, 4'b1101);
        goto(22); number = 16'hABCD;
        goto(25); chk("1234 d2", seg_w[0], en_w[0], 7'b0010010, 4'b1011);
        goto(29); chk("1234 d3", seg_w[0], en_w[0], 7'b1001111, 4'b0111);
        goto(30); chk("fast d1 C", seg_w[2], en_w[2], 7'b0110001, 4'b1101);
        goto(31); chk("fast d2 b", seg_w[2], en_w[2], 7'b1100000, 4'b1011);
        goto(33); chk("ABCD d0", seg_w[0], en_w[0], 7'b1000010, 4'b1110);
        goto(45); hold = 1'b1; number = 16'hFFFF;
        goto(49); chk("hold keeps d", seg_w[0], en_w[0], 7'b1000010, 4'b1110);
        hold = 1'b0;
        goto(65); chk("FFFF d0", seg_w[0], en_w[0], 7'b0111000, 4'b1110);
        number = 16'h0040;
        goto(77); chk("FFFF d3", seg_w[0], en_w[0], 7'b0111000, 4'b0111);
        goto(81); chk("lz d0", seg_w[1], en_w[1], 7'b0000001, 4'b1110);
        goto(85); chk("lz d1", seg_w[1], en_w[1], 7'b1001100, 4'b1101);
        goto(89); chk("lz d2 blank", seg_w[1], en_w[1], 7'h7F, 4'hF);
        goto(93); chk("lz d3 blank", seg_w[1], en_w[1], 7'h7F, 4'hF);
        enable = 4'b1110;
        goto(97);  chk("lz d0 disabled", seg_w[1], en_w[1], 7'h7F, 4'hF);
        goto(101); chk("lz d1 live", seg_w[1], en_w[1], 7'b1001100, 4'b1101);
        enable = 4'hF;

        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("async u%0d", i), seg_w[i], en_w[i], 7'h7F, 4'hF);
        #1 reset = 1'b0;
        goto(1); chk("fast restart d0", seg_w[2], en_w[2], 7'b0000001, 4'b1110);
        goto(2); chk("fast restart d1", seg_w[2], en_w[2], 7'b0000001, 4'b1101);
        goto(3); chk("fast restart d2", seg_w[2], en_w[2], 7'b0000001, 4'b1011);
        goto(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
